// File: rtl/maxpool_pkg.sv
// maxpool_pkg: shared state encoding, lane geometry and pooled-size helper
// for the max-pool sequencer.
package maxpool_pkg;
   localparam int LANES = 64;
   localparam int DW = 16;
   typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;
   function automatic int pool_dim(input int in, input int k, input int s);
      return (in - k) / s + 1;
   endfunction
endpackage

// File: rtl/maxpool_sched_if.sv
// maxpool_sched_if: input-buffer read, pool-array and output-buffer write
// signals between maxpool_sched (master) and its datapath (slave).
interface maxpool_sched_if
   import maxpool_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int DATA_W = LANES * DW
);
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              pool_valid;
   logic [DATA_W-1:0] pool_data;
   logic [DATA_W-1:0] pool_out;
   logic              pool_out_valid;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   modport master (output rd_en, rd_addr, pool_valid, pool_data, wr_en, wr_addr, wr_data,
                   input rd_data, pool_out, pool_out_valid);
   modport slave (input rd_en, rd_addr, pool_valid, pool_data, wr_en, wr_addr, wr_data,
                  output rd_data, pool_out, pool_out_valid);
endinterface

// File: rtl/maxpool_sched_wdog.sv
// maxpool_sched_wdog: counts consecutive enabled cycles without progress and
// flags expiry on the LIMIT-th one.
module maxpool_sched_wdog #(
   parameter int LIMIT = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic expire
);
   localparam int CW = $clog2(LIMIT + 1);
   localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);
   logic [CW-1:0] cnt;
   assign expire = en && !clr && cnt == LAST;
   always_ff @(posedge clk) begin
      cnt <= (rst || !en || clr) ? '0 : cnt + 1'b1;
   end
endmodule

// File: rtl/maxpool_sched.sv
// maxpool_sched: streams one feature map into the max-pool array and writes the
// pooled words out; MAXPOOL_SCHED_TIMEOUT_EN adds a drain watchdog driving err.
module maxpool_sched
   import maxpool_pkg::*;
#(
   parameter int LANES = maxpool_pkg::LANES,
   parameter int DW = maxpool_pkg::DW,
   parameter int IN_W = 27,
   parameter int IN_H = 27,
   parameter int POOL_K = 3,
   parameter int POOL_S = 2,
   parameter int ADDR_W = 16,
   parameter int DRAIN_TIMEOUT = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic abort,
   output logic busy,
   output logic done,
   output logic err,
   maxpool_sched_if.master bus
);
   localparam int DATA_W = LANES * DW;
   localparam int N_IN = IN_W * IN_H;
   localparam int N_OUT = pool_dim(IN_W, POOL_K, POOL_S) * pool_dim(IN_H, POOL_K, POOL_S);
   localparam logic [ADDR_W-1:0] LAST_RD = ADDR_W'(N_IN - 1);
   localparam logic [ADDR_W-1:0] OUT_END = ADDR_W'(N_OUT);

   if (N_IN > (longint'(1) << ADDR_W) || DRAIN_TIMEOUT < 1) begin : g_bad_cfg
      $error("maxpool_sched: map does not fit ADDR_W or DRAIN_TIMEOUT < 1");
   end

   state_t state, next;
   logic [ADDR_W-1:0] rd_addr, out_cnt, wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic pool_valid, wr_en, go, accept, expire;

   assign go = state == IDLE && start && !abort;
   // Outputs past N_OUT are dropped so a chatty pool array cannot overrun the map.
   assign accept = (state == FEED || state == DRAIN) && bus.pool_out_valid && out_cnt != OUT_END;
   assign busy = state != IDLE;
   assign done = state == DONE;
   assign bus.rd_en = state == FEED;
   assign bus.rd_addr = rd_addr;
   assign bus.pool_valid = pool_valid;
   assign bus.pool_data = pool_valid ? bus.rd_data : '0;
   assign bus.wr_en = wr_en;
   assign bus.wr_addr = wr_addr;
   assign bus.wr_data = wr_data;

   always_comb begin
      next = state;
      case (state)
         IDLE:    next = go ? FEED : IDLE;
         FEED:    next = abort ? IDLE : (rd_addr == LAST_RD ? DRAIN : FEED);
         DRAIN:   next = abort ? IDLE : ((out_cnt == OUT_END || expire) ? DONE : DRAIN);
         default: next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         rd_addr <= '0;
         out_cnt <= '0;
         wr_addr <= '0;
         wr_data <= '0;
         wr_en <= 1'b0;
         pool_valid <= 1'b0;
      end else begin
         state <= next;
         pool_valid <= bus.rd_en;
         wr_en <= accept;
         rd_addr <= go ? '0 : rd_addr + ADDR_W'(state == FEED);
         out_cnt <= go ? '0 : out_cnt + ADDR_W'(accept);
         wr_addr <= go ? '0 : (accept ? out_cnt : wr_addr);
         if (accept) wr_data <= bus.pool_out;
      end
   end

`ifdef MAXPOOL_SCHED_TIMEOUT_EN
   maxpool_sched_wdog #(.LIMIT(DRAIN_TIMEOUT)) u_wdog (
      .clk(clk),
      .rst(rst),
      .en(state == DRAIN && !abort),
      .clr(accept),
      .expire(expire)
   );
   always_ff @(posedge clk) begin
      err <= (rst || go) ? 1'b0 : (err | expire);
   end
`else
   assign expire = 1'b0;
   assign err = 1'b0;
`endif
endmodule

// File: tb/tb_maxpool_sched.sv
// tb_maxpool_sched: scoreboard bench for a 5x5 and a 27x27 maxpool_sched, with a
// registered buffer model and a pool-array model emitting one word per window.
module tb_maxpool_sched;
   import maxpool_pkg::*;
   localparam int BW = LANES * DW;

   logic clk = 1'b0;
   logic rst;
   logic [1:0] start, abort, busy, done, err, hold, stray;
   int rd_cnt[2], pv_cnt[2], wr_cnt[2], done_cnt[2];
   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   function automatic logic [BW-1:0] pix(input logic [15:0] a);
      return {LANES{a ^ 16'hA5C3}};
   endfunction

   task automatic chk(input string tag, input logic [BW-1:0] o, input logic [BW-1:0] e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o[127:0], e[127:0]);
      end
   endtask

   for (genvar i = 0; i < 2; i++) begin : g
      localparam int W = i ? 27 : 5;
      localparam int OW = (W - 3) / 2 + 1;
      localparam int NO = OW * OW;
      maxpool_sched_if #(.ADDR_W(16), .DATA_W(BW)) bus ();
      maxpool_sched #(.IN_W(W), .IN_H(W), .DRAIN_TIMEOUT(i ? 1024 : 8)) dut (
         .clk(clk), .rst(rst), .start(start[i]), .abort(abort[i]), .busy(busy[i]),
         .done(done[i]), .err(err[i]), .bus(bus)
      );
      logic mv = 1'b0;
      logic [BW-1:0] mdata = '0;
      logic prev_pv = 1'b0, prev_rd = 1'b0;
      logic [15:0] last_rd = '0;
      int pidx = 0;
      logic [BW-1:0] exp_q[$];
      logic [15:0] addr_q[$];
      assign bus.pool_out_valid = mv | stray[i];
      assign bus.pool_out = mdata;

      always @(posedge clk) bus.rd_data <= bus.rd_en ? pix(bus.rd_addr) : '0;

      // Pool model: a word appears after the bottom-right pixel of each window.
      always @(posedge clk) begin
         int n, r, c, o;
         logic [BW-1:0] d;
         n = bus.pool_valid ? (prev_pv ? pidx + 1 : 0) : pidx;
         mv <= 1'b0;
         if (bus.pool_valid) begin
            r = n / W;
            c = n % W;
            if (r >= 2 && c >= 2 && (r - 2) % 2 == 0 && (c - 2) % 2 == 0) begin
               o = (r - 2) / 2 * OW + (c - 2) / 2;
               if (!(hold[i] && o == NO - 1)) begin
                  d = {32{32'($urandom())}};
                  mv <= 1'b1;
                  mdata <= d;
                  exp_q.push_back(d);
                  addr_q.push_back(16'(o));
               end
            end
         end
         pidx <= n;
         prev_pv <= bus.pool_valid;
      end

      always @(negedge clk) begin
         if (bus.rd_en) begin
            chk("rd_addr", bus.rd_addr, prev_rd ? last_rd + 16'd1 : 16'd0);
            rd_cnt[i] <= rd_cnt[i] + 1;
            last_rd <= bus.rd_addr;
         end
         prev_rd <= bus.rd_en;
         if (bus.pool_valid) begin
            chk("pool_data", bus.pool_data, pix(last_rd));
            pv_cnt[i] <= pv_cnt[i] + 1;
         end
         if (bus.wr_en) begin
            wr_cnt[i] <= wr_cnt[i] + 1;
            if (exp_q.size() == 0) chk("spurious_wr", bus.wr_en, 1'b0);
            else begin
               chk("wr_addr", bus.wr_addr, addr_q.pop_front());
               chk("wr_data", bus.wr_data, exp_q.pop_front());
            end
         end
         if (done[i]) done_cnt[i] <= done_cnt[i] + 1;
      end
   end

   task automatic clr_cnt();
      for (int i = 0; i < 2; i++) begin
         rd_cnt[i] = 0;
         pv_cnt[i] = 0;
         wr_cnt[i] = 0;
         done_cnt[i] = 0;
      end
   endtask

   task automatic pulse_start(input int i);
      @(negedge clk) start[i] = 1'b1;
      @(negedge clk) start[i] = 1'b0;
   endtask

   task automatic wait_done(input int i, input int lim);
      int n = 0;
      while (!done[i] && n < lim) begin
         @(negedge clk);
         n++;
      end
      chk("done_seen", done[i], 1'b1);
   endtask

   task automatic chk_idle0();
      chk("busy0", busy[0], 1'b0);
      chk("done0", done[0], 1'b0);
      chk("err0", err[0], 1'b0);
      chk("rd_en0", g[0].bus.rd_en, 1'b0);
      chk("rd_addr0", g[0].bus.rd_addr, 16'd0);
      chk("pool_valid0", g[0].bus.pool_valid, 1'b0);
      chk("pool_data0", g[0].bus.pool_data, '0);
      chk("wr_en0", g[0].bus.wr_en, 1'b0);
      chk("wr_addr0", g[0].bus.wr_addr, 16'd0);
      chk("wr_data0", g[0].bus.wr_data, '0);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      rst = 1'b1; start = '0; abort = '0; hold = '0; stray = '0;
      clr_cnt();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk_idle0();
      chk("busy1", busy[1], 1'b0);

      // 5x5 map: 25 reads, 4 writes, one done
      pulse_start(0);
      chk("t1_busy", busy[0], 1'b1);
      chk("t1_rd_en", g[0].bus.rd_en, 1'b1);
      chk("t1_rd_addr", g[0].bus.rd_addr, 16'd0);
      chk("t1_pv_lat0", g[0].bus.pool_valid, 1'b0);
      @(negedge clk);
      chk("t1_pv_lat1", g[0].bus.pool_valid, 1'b1);
      wait_done(0, 100);
      chk("t1_busy_done", busy[0], 1'b1);
      @(negedge clk);
      chk("t1_busy_after", busy[0], 1'b0);
      chk("t1_done_once", done[0], 1'b0);
      chk("t1_reads", rd_cnt[0], 25);
      chk("t1_pvs", pv_cnt[0], 25);
      chk("t1_writes", wr_cnt[0], 4);
      chk("t1_dones", done_cnt[0], 1);

      // 27x27 back-to-back
      clr_cnt();
      pulse_start(1);
      wait_done(1, 2000);
      @(negedge clk);
      chk("t2_idle_gap", busy[1], 1'b0);
      start[1] = 1'b1;
      @(negedge clk) start[1] = 1'b0;
      chk("t2_restart", busy[1], 1'b1);
      chk("t2_rd_addr", g[1].bus.rd_addr, 16'd0);
      wait_done(1, 2000);
      repeat (2) @(negedge clk);
      chk("t2_reads", rd_cnt[1], 1458);
      chk("t2_writes", wr_cnt[1], 338);
      chk("t2_dones", done_cnt[1], 2);

      // start held while busy, then start+abort together in IDLE
      clr_cnt();
      @(negedge clk) start[0] = 1'b1;
      repeat (15) @(negedge clk);
      start[0] = 1'b0;
      wait_done(0, 100);
      repeat (2) @(negedge clk);
      start[0] = 1'b1; abort[0] = 1'b1;
      @(negedge clk) begin start[0] = 1'b0; abort[0] = 1'b0; end
      chk("t3_abort_wins", busy[0], 1'b0);
      repeat (5) @(negedge clk);
      chk("t3_reads", rd_cnt[0], 25);
      chk("t3_dones", done_cnt[0], 1);

      // abort at read 10
      clr_cnt();
      pulse_start(0);
      repeat (10) @(negedge clk);
      chk("t4_at10", g[0].bus.rd_addr, 16'd10);
      abort[0] = 1'b1;
      @(negedge clk) abort[0] = 1'b0;
      chk("t4_rd_en", g[0].bus.rd_en, 1'b0);
      chk("t4_busy", busy[0], 1'b0);
      repeat (3) @(negedge clk);
      chk("t4_reads", rd_cnt[0], 11);
      chk("t4_pvs", pv_cnt[0], 11);
      chk("t4_nodone", done_cnt[0], 0);
      pulse_start(0);
      chk("t4_rd_addr", g[0].bus.rd_addr, 16'd0);
      wait_done(0, 100);
      repeat (2) @(negedge clk);
      chk("t4_writes", wr_cnt[0], 4);
      chk("t4_dones", done_cnt[0], 1);

      // rst mid-DRAIN, then a stray pool_out_valid in IDLE
      clr_cnt();
      hold[0] = 1'b1;
      pulse_start(0);
      repeat (29) @(negedge clk);
      chk("t5_in_drain", {busy[0], g[0].bus.rd_en}, 2'b10);
      rst = 1'b1;
      @(negedge clk) rst = 1'b0;
      chk_idle0();
      stray[0] = 1'b1;
      @(negedge clk) stray[0] = 1'b0;
      repeat (3) @(negedge clk);
      chk("t5_writes", wr_cnt[0], 3);
      chk("t5_nodone", done_cnt[0], 0);

`ifdef MAXPOOL_SCHED_TIMEOUT_EN
      // watchdog fires after 8 stalled DRAIN cycles
      clr_cnt();
      pulse_start(0);
      n = 0;
      while (g[0].bus.rd_en && n < 100) begin
         @(negedge clk);
         n++;
      end
      n = 0;
      while (!done[0] && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("t6_latency", n, 8);
      chk("t6_err", err[0], 1'b1);
      @(negedge clk);
      chk("t6_err_sticky", err[0], 1'b1);
      hold[0] = 1'b0;
      pulse_start(0);
      chk("t6_err_clear", err[0], 1'b0);
      wait_done(0, 100);
      chk("t6_err_clean", err[0], 1'b0);
`else
      // no watchdog: DRAIN waits until aborted
      clr_cnt();
      pulse_start(0);
      repeat (60) @(negedge clk);
      chk("t6_still_busy", busy[0], 1'b1);
      chk("t6_err_zero", err[0], 1'b0);
      chk("t6_nodone", done_cnt[0], 0);
      abort[0] = 1'b1;
      @(negedge clk) abort[0] = 1'b0;
      chk("t6_abort_drain", busy[0], 1'b0);
      hold[0] = 1'b0;
`endif
      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/maxpool_sched.md
# maxpool_sched

Sequencer for the 64-lane 3×3 max-pool array. On a start pulse it streams one feature map out of the conv output buffer into the pool array, one pixel word per cycle. The word carries 64 channels × 16 bits. It then collects the pooled words and writes them to the pool output buffer at consecutive addresses, and signals done. It sits between the conv-layer controller (start/done) and the pool array plus its two buffers.

## Interface
Parameters:
- LANES, 64, channels per word
- DW, 16, bits per channel
- IN_W, 27, input map width
- IN_H, 27, input map height
- POOL_K, 3, window size
- POOL_S, 2, stride
- ADDR_W, 16, buffer address width
- DRAIN_TIMEOUT, 1024, watchdog limit in cycles (used only with the macro)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to pool one map
- abort  in  1  one-cycle request to cancel the current map
- busy  out  1  high while a map is in progress
- done  out  1  one-cycle pulse when the map is complete
- err  out  1  sticky watchdog error (macro only; otherwise tied 0)
- rd_en  out  1  input buffer read strobe
- rd_addr  out  ADDR_W  input pixel address
- rd_data  in  LANES*DW  read data, valid the cycle after rd_en
- pool_valid  out  1  drives the pool array's i_data_valid
- pool_data  out  LANES*DW  pool array input
- pool_out  in  LANES*DW  pool array output
- pool_out_valid  in  1  OR of all lane valids
- wr_en  out  1  output buffer write strobe
- wr_addr  out  ADDR_W  output pixel address
- wr_data  out  LANES*DW  write data

## Operation
- Derived constants:
  - OUT_W = (IN_W−POOL_K)/POOL_S+1; OUT_H likewise from IN_H.
  - N_IN = IN_W*IN_H; N_OUT = OUT_W*OUT_H.
  - Defaults give 27×27 → 13×13, N_IN=729, N_OUT=169.
- States:
  - IDLE: waits for start.
  - FEED: issues reads.
  - DRAIN: waits for the remaining pooled outputs.
  - DONE: raises done.
- IDLE→FEED on start with abort low. Clears rd_addr, out_cnt and wr_addr.
- FEED:
  - rd_en=1 every cycle; rd_addr increments 0..N_IN−1.
  - After issuing address N_IN−1, go to DRAIN.
- DRAIN→DONE in the cycle out_cnt reaches N_OUT.
- DONE: done=1 for exactly one cycle, then →IDLE.
- pool_valid and pool_data are rd_en and rd_data delayed one cycle, matching buffer latency. pool_valid is therefore high for exactly N_IN cycles per map.
- Output capture, while in FEED or DRAIN when pool_out_valid=1:
  - wr_en=1, wr_data=pool_out, wr_addr=out_cnt.
  - out_cnt and wr_addr increment.
- pool_out_valid in IDLE or DONE: ignored, no write.
- Extra pool_out_valid after out_cnt=N_OUT: ignored.
- abort in FEED or DRAIN: →IDLE next cycle, no done pulse. rd_en is deasserted that same next cycle. Writes already issued stay in the buffer.
- start while busy: ignored.
- start and abort in the same IDLE cycle: abort wins, stays IDLE.
- Counter widths: rd_addr, wr_addr and out_cnt are ADDR_W bits. N_IN ≤ 2^ADDR_W is a synthesis-time assertion.

## Timing
- Reset values: busy=0, done=0, err=0, rd_en=0, rd_addr=0, pool_valid=0, pool_data=0, wr_en=0, wr_addr=0, wr_data=0, state=IDLE.
- rst mid-map returns everything to reset values on the next edge.
- Start at cycle t:
  - busy=1 and rd_en=1 with rd_addr=0 at t+1.
  - pool_valid=1 at t+2.
  - Last read at t+N_IN; last pool_valid at t+N_IN+1.
- Write path is registered: wr_en follows pool_out_valid by one cycle.
- busy=1 from t+1 through the DONE cycle, and 0 the cycle after it.
- Back-to-back maps: start may be accepted in the first IDLE cycle after DONE.

## Configuration
- MAXPOOL_SCHED_TIMEOUT_EN defined:
  - A watchdog counts DRAIN cycles and resets on every accepted pool_out_valid.
  - When it reaches DRAIN_TIMEOUT, set err=1 and go →DONE; done still pulses.
  - err clears only on rst or the next accepted start.
- Undefined: no watchdog; err is constant 0; DRAIN waits indefinitely.

## Structure
- Shared package maxpool_pkg holds:
  - the state enum (IDLE, FEED, DRAIN, DONE);
  - LANES and DW;
  - a function computing the pooled dimension from in, k and s.
- One sub-module, maxpool_sched_wdog: the watchdog counter, instantiated only under MAXPOOL_SCHED_TIMEOUT_EN.
- Everything else stays flat in maxpool_sched.

## Test plan
1. IN_W=IN_H=5, K=3, S=2, model pool array emits 4 valids:
   - rd_addr 0..24, 25 pool_valid pulses;
   - 4 writes at wr_addr 0..3, wr_data matching pool_out;
   - one done pulse.
2. Default sizes, back-to-back starts:
   - each map gives 729 reads and 169 writes;
   - second map's wr_addr restarts at 0;
   - two done pulses.
3. start held while busy, and start+abort together in IDLE:
   - no restart and no extra done in either case.
4. abort at read 10:
   - rd_en low the next cycle, busy=0, no done;
   - a later start runs cleanly from rd_addr=0.
5. rst asserted mid-DRAIN: all outputs return to reset values; pool_out_valid afterwards produces no write.
6. With MAXPOOL_SCHED_TIMEOUT_EN and DRAIN_TIMEOUT=8, model withholds the last output:
   - err=1 and done pulses 8 cycles into the stall;
   - err clears on the next start.
